// File: rtl/spi_byte_master.sv
// spi_byte_master: mode-0 MSB-first SPI byte shifter on a toggle req/ack byte port.
module spi_byte_master #(
  parameter int HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_req,
  output logic       spi_ack,
  input  logic [7:0] spi_d,
  output logic [7:0] spi_q,
  input  logic       spi_cs_n,
  output logic       flash_cs_n,
  output logic       flash_sck,
  output logic       flash_mosi,
  input  logic       flash_miso,
  output logic       busy
);
  localparam int CW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] CMAX = CW'(HALF_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bitc, bitc_n;
  logic [7:0] sh, sh_n, q_n;
  logic mosi_n, sck_n, ack_n, busy_n, expire;
  assign expire = cnt == '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bitc_n = bitc;
    sh_n = sh;
    q_n = spi_q;
    mosi_n = flash_mosi;
    sck_n = flash_sck;
    ack_n = spi_ack;
    busy_n = busy;
    case (state)
      IDLE: if (spi_req != spi_ack) begin
        sh_n = spi_d;
        mosi_n = spi_d[7];
        bitc_n = '0;
        busy_n = 1'b1;
        cnt_n = CMAX;
        state_n = LOW;
      end
      LOW: if (expire) begin
        sck_n = 1'b1;
        sh_n = {sh[6:0], flash_miso};
        cnt_n = CMAX;
        state_n = HIGH;
      end else cnt_n = cnt - 1'b1;
      HIGH: if (expire) begin
        sck_n = 1'b0;
        cnt_n = CMAX;
        if (bitc != 3'd7) begin
          bitc_n = bitc + 3'd1;
          mosi_n = sh[7];
          state_n = LOW;
        end else begin
          q_n = sh;
          ack_n = ~spi_ack;
          busy_n = 1'b0;
          state_n = IDLE;
        end
      end else cnt_n = cnt - 1'b1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    flash_cs_n <= reset ? 1'b1 : spi_cs_n;
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bitc <= '0;
      sh <= '0;
      spi_q <= '0;
      flash_mosi <= 1'b0;
      flash_sck <= 1'b0;
      spi_ack <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bitc <= bitc_n;
      sh <= sh_n;
      spi_q <= q_n;
      flash_mosi <= mosi_n;
      flash_sck <= sck_n;
      spi_ack <= ack_n;
      busy <= busy_n;
    end
  end
endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: scoreboard bench driving HALF_PERIOD=1 and HALF_PERIOD=3 instances.
module tb_spi_byte_master;
  typedef struct packed {
    logic [7:0] q;
    logic [7:0] mo;
    int lat;
    int bz;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req[2] = '{1'b0, 1'b0};
  logic cs_n[2] = '{1'b1, 1'b1};
  logic [7:0] d[2] = '{8'h00, 8'h00};
  logic [7:0] mb[2] = '{8'h00, 8'h00};
  logic ack[2], fcs[2], sck[2], mosi[2], miso[2], busy[2];
  logic [7:0] q[2];
  logic [2:0] idx[2];
  logic pack[2] = '{1'b0, 1'b0};
  logic psck[2] = '{1'b0, 1'b0};
  logic pcs[2] = '{1'b1, 1'b1};
  logic prst = 1'b1;
  logic [7:0] mcap[2] = '{8'h00, 8'h00};
  logic [7:0] lq[2] = '{8'h00, 8'h00};
  int bcnt[2] = '{0, 0};
  int hcnt[2] = '{0, 0};
  int hp[2] = '{1, 3};
  time treq[2] = '{0, 0};
  exp_t sb[2][$];
  exp_t e;
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  spi_byte_master #(.HALF_PERIOD(1)) u0 (
    .clk(clk), .reset(reset), .spi_req(req[0]), .spi_ack(ack[0]), .spi_d(d[0]), .spi_q(q[0]),
    .spi_cs_n(cs_n[0]), .flash_cs_n(fcs[0]), .flash_sck(sck[0]), .flash_mosi(mosi[0]),
    .flash_miso(miso[0]), .busy(busy[0])
  );
  spi_byte_master #(.HALF_PERIOD(3)) u1 (
    .clk(clk), .reset(reset), .spi_req(req[1]), .spi_ack(ack[1]), .spi_d(d[1]), .spi_q(q[1]),
    .spi_cs_n(cs_n[1]), .flash_cs_n(fcs[1]), .flash_sck(sck[1]), .flash_mosi(mosi[1]),
    .flash_miso(miso[1]), .busy(busy[1])
  );
  // flash model: presents bit 7 first, advances one bit on every SCK fall
  assign miso[0] = mb[0][~idx[0]];
  assign miso[1] = mb[1][~idx[1]];
  task automatic chk(input string nm, input int got, input int want);
    n_assert++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("cs_track", fcs[i], prst ? 1 : pcs[i]);
      if (reset) begin
        idx[i] <= 3'd0;
        bcnt[i] = 0;
        hcnt[i] = 0;
        mcap[i] = 8'h00;
      end else begin
        if (sck[i] != psck[i]) chk("sck_edge_cs_low", fcs[i], 0);
        if (sck[i] && !psck[i]) mcap[i] = {mcap[i][6:0], mosi[i]};
        if (sck[i]) hcnt[i]++;
        else if (psck[i]) begin
          chk("sck_high_len", hcnt[i], hp[i]);
          hcnt[i] = 0;
        end
        if (ack[i] != pack[i]) begin
          if (sb[i].size() == 0) chk("unexpected_ack", 1, 0);
          else begin
            e = sb[i].pop_front();
            chk("spi_q", q[i], e.q);
            chk("mosi_byte", mcap[i], e.mo);
            chk("ack_latency", int'(($time - treq[i]) / 10), e.lat);
            chk("busy_len", bcnt[i], e.bz);
          end
          bcnt[i] = 0;
        end else chk("q_hold", q[i], lq[i]);
        if (busy[i]) bcnt[i]++;
        if (!busy[i]) idx[i] <= 3'd0;
        else if (psck[i] && !sck[i]) idx[i] <= idx[i] + 3'd1;
      end
      pack[i] = ack[i];
      psck[i] = sck[i];
      pcs[i] = cs_n[i];
      lq[i] = q[i];
    end
    prst = reset;
  end
  task automatic send(input int i, input logic [7:0] dv, input logic [7:0] mv, input logic [7:0] eq);
    mb[i] = mv;
    d[i] = dv;
    @(posedge clk);
    treq[i] = $time;
    #1 req[i] = ~req[i];
    sb[i].push_back(exp_t'{eq, dv, i == 1 ? 49 : 17, i == 1 ? 48 : 16});
    @(posedge clk);
    #1 d[i] = ~dv;
    for (int k = 0; k < 200 && ack[i] != req[i]; k++) @(posedge clk);
    #1 chk("ack_timeout", ack[i], req[i]);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 cs_n = '{1'b0, 1'b0};
    @(posedge clk);
    send(0, 8'hA5, 8'h3C, 8'h3C);
    send(0, 8'h81, 8'h55, 8'h55);
    #1 cs_n[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 cs_n[0] = 1'b0;
    send(0, 8'h03, 8'h00, 8'h00);
    send(0, 8'h12, 8'h00, 8'h00);
    send(0, 8'h34, 8'h00, 8'h00);
    send(0, 8'h56, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) send(0, 8'h00, 8'h11 + 8'(k), 8'h11 + 8'(k));
    @(posedge clk);
    #1 cs_n[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 cs_n[0] = 1'b0;
    mb[0] = 8'h0F;
    d[0] = 8'hF0;
    @(posedge clk);
    #1 req[0] = ~req[0];
    repeat (6) @(posedge clk);
    #1 chk("pre_reset_busy", busy[0], 1);
    chk("pre_reset_sck", sck[0], 1);
    chk("pre_reset_mosi", mosi[0], 1);
    reset = 1'b1;
    req = '{1'b0, 1'b0};
    @(posedge clk);
    @(negedge clk);
    chk("rst_sck", sck[0], 0);
    chk("rst_mosi", mosi[0], 0);
    chk("rst_ack", ack[0], 0);
    chk("rst_q", q[0], 8'h00);
    chk("rst_busy", busy[0], 0);
    chk("rst_cs", fcs[0], 1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    send(0, 8'hC6, 8'h9A, 8'h9A);
    send(1, 8'hFF, 8'h00, 8'h00);
    send(1, 8'h5A, 8'hC3, 8'hC3);
    repeat (5) @(posedge clk);
    chk("sb_empty", sb[0].size() + sb[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
